// File: rtl/mac_vec_pipe_pkg.sv
// mac_pkg: shared accumulate-mode encoding and requantisation helper for the MAC pipeline
package mac_pkg;
  typedef enum logic [1:0] {
    ACC_ZERO     = 2'd0,
    ACC_PSUM     = 2'd1,
    ACC_INTERNAL = 2'd2
  } acc_mode_e;
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc, input int shift, input int out_w);
    logic signed [63:0] sh, hi, lo;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return sh > hi ? hi : sh < lo ? lo : sh;
  endfunction
endpackage

// File: rtl/mac_vec_pipe_if.sv
// mac_vec_pipe_if: operand/psum/tag input beat and raw/requantised output beat with valid/ready
interface mac_vec_pipe_if
  import mac_pkg::*;
#(
  parameter int K         = 3,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int TAG_WIDTH = 20
);
  logic                        in_valid;
  logic                        in_ready;
  logic [K*A_WIDTH-1:0]        a;
  logic [K*B_WIDTH-1:0]        b;
  acc_mode_e                   acc_mode;
  logic signed [ACC_WIDTH-1:0] psum_in;
  logic                        last;
  logic [TAG_WIDTH-1:0]        tag_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] acc_out;
  logic signed [OUT_WIDTH-1:0] q_out;
  logic [TAG_WIDTH-1:0]        tag_out;
  modport master (
    output in_valid, a, b, acc_mode, psum_in, last, tag_in, out_ready,
    input  in_ready, out_valid, acc_out, q_out, tag_out
  );
  modport slave (
    input  in_valid, a, b, acc_mode, psum_in, last, tag_in, out_ready,
    output in_ready, out_valid, acc_out, q_out, tag_out
  );
endinterface

// File: rtl/mac_vec_pipe_adder_tree.sv
// mac_adder_tree: registered signed reduction of K products, widened by clog2(K) so it never overflows
module mac_adder_tree #(
  parameter int K    = 3,
  parameter int IN_W = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en_i,
  input  logic [K*IN_W-1:0]                    in_i,
  output logic signed [IN_W+$clog2(K)-1:0]     sum_o
);
  localparam int OW = IN_W + $clog2(K);
  logic signed [OW-1:0] sum_d, sum_q;
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < K; i++) sum_d = sum_d + OW'($signed(in_i[i*IN_W +: IN_W]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else if (en_i) sum_q <= sum_d;
  assign sum_o = sum_q;
endmodule

// File: rtl/mac_vec_pipe.sv
// mac_vec_pipe: 4-stage K-tap signed dot-product MAC with accumulate modes, tag sideband and requantised output
module mac_vec_pipe
  import mac_pkg::*;
#(
  parameter int K         = 3,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 0,
  parameter int TAG_WIDTH = 20
) (
  input logic           clk,
  input logic           arst_n_in,
  mac_vec_pipe_if.slave bus
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int SW = PW + $clog2(K);
  logic                        stall;
  logic                        v1_q, v2_q, v3_q, ov_q;
  logic [K*A_WIDTH-1:0]        a1_q;
  logic [K*B_WIDTH-1:0]        b1_q;
  acc_mode_e                   m1_q, m2_q, m3_q;
  logic                        l1_q, l2_q, l3_q;
  logic [TAG_WIDTH-1:0]        t1_q, t2_q, t3_q, tag_q;
  logic [K*PW-1:0]             p2_d, p2_q;
  logic signed [SW-1:0]        sum3;
  logic signed [ACC_WIDTH-1:0] base, acc_d, acc_q, acc_out_q;
  logic signed [OUT_WIDTH-1:0] q_d, q_q;
  // a held output freezes every stage, so beats never overtake or drop
  assign stall        = ov_q && !bus.out_ready;
  assign bus.in_ready = !stall;
  always_comb begin
    p2_d = '0;
    for (int i = 0; i < K; i++)
      p2_d[i*PW +: PW] = PW'($signed(a1_q[i*A_WIDTH +: A_WIDTH])) * PW'($signed(b1_q[i*B_WIDTH +: B_WIDTH]));
  end
  mac_adder_tree #(.K(K), .IN_W(PW)) u_tree (
    .clk(clk), .rst_n(arst_n_in), .en_i(!stall), .in_i(p2_q), .sum_o(sum3)
  );
  always_comb begin
    base  = m3_q == ACC_PSUM ? bus.psum_in : m3_q == ACC_INTERNAL ? acc_q : '0;
    acc_d = base + ACC_WIDTH'(sum3);
    q_d   = OUT_WIDTH'(sat_shift(64'(acc_d), OUT_SHIFT, OUT_WIDTH));
  end
  always_ff @(posedge clk or negedge arst_n_in)
    if (!arst_n_in) begin
      {v1_q, v2_q, v3_q, ov_q} <= '0;
      {a1_q, b1_q, p2_q}       <= '0;
      {m1_q, m2_q, m3_q}       <= {ACC_ZERO, ACC_ZERO, ACC_ZERO};
      {l1_q, l2_q, l3_q}       <= '0;
      {t1_q, t2_q, t3_q}       <= '0;
      {acc_q, acc_out_q}       <= '0;
      q_q                      <= '0;
      tag_q                    <= '0;
    end else if (!stall) begin
      v1_q <= bus.in_valid;
      a1_q <= bus.a;
      b1_q <= bus.b;
      m1_q <= bus.acc_mode;
      l1_q <= bus.last;
      t1_q <= bus.tag_in;
      {v2_q, m2_q, l2_q, t2_q, p2_q} <= {v1_q, m1_q, l1_q, t1_q, p2_d};
      {v3_q, m3_q, l3_q, t3_q}       <= {v2_q, m2_q, l2_q, t2_q};
      if (v3_q) acc_q <= acc_d;
      // not stalled means any shown output was taken, so out_valid follows the S4 beat
      ov_q <= v3_q && l3_q;
      if (v3_q && l3_q) begin
        acc_out_q <= acc_d;
        q_q       <= q_d;
        tag_q     <= t3_q;
      end
    end
  assign bus.out_valid = ov_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.q_out     = q_q;
  assign bus.tag_out   = tag_q;
endmodule

// File: tb/tb_mac_vec_pipe.sv
// tb_mac_vec_pipe: scoreboard bench for mac_vec_pipe (K=3, OUT_SHIFT=2)
module tb_mac_vec_pipe;
  import mac_pkg::*;
  localparam int K = 3, AW = 16, BW = 16, ACW = 32, OW = 16, SH = 2, TW = 20;
  typedef struct packed {
    logic [ACW-1:0] acc;
    logic [OW-1:0]  q;
    logic [TW-1:0]  tag;
  } beat_t;
  logic clk = 1'b0;
  logic arst_n_in;
  beat_t exp_q[$], obs_q[$];
  beat_t e, o;
  int checks = 0, errors = 0;
  longint model_acc = 0;
  mac_vec_pipe_if #(.K(K), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACW), .OUT_WIDTH(OW), .TAG_WIDTH(TW)) bus();
  mac_vec_pipe #(.K(K), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACW), .OUT_WIDTH(OW), .OUT_SHIFT(SH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #1;
    if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.acc_out, bus.q_out, bus.tag_out});
  end
  task automatic send(input logic [K*AW-1:0] av, input logic [K*BW-1:0] bv, input logic [1:0] mode, input logic lst, input int tag);
    longint dot, base, sh, q;
    logic signed [ACW-1:0] t32;
    int n;
    bus.a = av; bus.b = bv; bus.acc_mode = acc_mode_e'(mode); bus.last = lst; bus.tag_in = TW'(tag); bus.in_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      #1;
      if (bus.in_ready) break;
      @(negedge clk);
    end
    if (n == 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=0 for 100 cycles, expected 1 (tag %0d)", tag);
    end else begin
      dot = 0;
      for (int i = 0; i < K; i++) dot += longint'($signed(av[i*AW +: AW])) * longint'($signed(bv[i*BW +: BW]));
      base = mode == 2'd1 ? longint'(bus.psum_in) : mode == 2'd2 ? model_acc : 0;
      t32 = ACW'(base + dot);
      model_acc = longint'(t32);
      if (lst) begin
        sh = model_acc >>> SH;
        q = sh > 32767 ? 32767 : sh < -32768 ? -32768 : sh;
        exp_q.push_back({t32, OW'(q), TW'(tag)});
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic test_reset();
    arst_n_in = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.psum_in = '0;
    bus.a = '0; bus.b = '0; bus.acc_mode = ACC_ZERO; bus.last = 1'b0; bus.tag_in = '0;
    repeat (3) @(negedge clk);
    arst_n_in = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.acc_out !== '0) begin errors++; $display("FAIL reset_acc_out: got %0d expected 0", bus.acc_out); end
    checks++; if (bus.q_out !== '0) begin errors++; $display("FAIL reset_q_out: got %0d expected 0", bus.q_out); end
    checks++; if (bus.tag_out !== '0) begin errors++; $display("FAIL reset_tag_out: got %0d expected 0", bus.tag_out); end
    @(negedge clk);
  endtask
  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d outputs expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_beat: got acc=%0d q=%0d tag=%0d expected acc=%0d q=%0d tag=%0d",
                 name, $signed(o.acc), $signed(o.q), o.tag, $signed(e.acc), $signed(e.q), e.tag);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_basic();
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4}, 2'd0, 1'b1, 'h5a5a5);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: out_valid=%b at cycle %0d expected 0", bus.out_valid, i + 1); end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%b at t+4 expected 1", bus.out_valid); end
    drain("basic");
  endtask
  task automatic test_accum();
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4}, 2'd0, 1'b0, 1);
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4}, 2'd2, 1'b0, 2);
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4}, 2'd2, 1'b1, 3);
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4}, 2'd3, 1'b1, 4);
    drain("accum");
  endtask
  task automatic test_psum();
    bus.psum_in = -32'sd100;
    send({16'd3, 16'd2, 16'd1}, {16'd6, 16'd5, 16'd4}, 2'd1, 1'b1, 7);
    drain("psum");
    bus.psum_in = '0;
  endtask
  task automatic test_saturate();
    send({16'd32767, 16'd32767, 16'd32767}, {16'd32767, 16'd32767, 16'd32767}, 2'd0, 1'b1, 8);
    send({16'd0, 16'd0, 16'd30000}, {16'd0, 16'd0, 16'd30000}, 2'd0, 1'b1, 9);
    drain("saturate");
  endtask
  task automatic test_back_to_back();
    fork
      for (int i = 0; i < 8; i++)
        send({16'($urandom), 16'($urandom), 16'($urandom)}, {16'($urandom), 16'($urandom), 16'($urandom)}, 2'd0, 1'b1, i);
      begin
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #1;
          checks++;
          if (bus.in_ready !== !bus.out_valid) begin errors++; $display("FAIL b2b_in_ready: got %b expected %b", bus.in_ready, !bus.out_valid); end
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stalled: in_ready=%b expected 0", bus.in_ready); end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain("b2b");
  endtask
  task automatic test_reset_flight();
    for (int i = 0; i < 3; i++) send({16'd1, 16'd1, 16'd1}, {16'd2, 16'd2, 16'd2}, 2'd0, 1'b1, 20 + i);
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flight_held: out_valid=%b expected 1", bus.out_valid); end
    arst_n_in = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flight_async_drop: out_valid=%b expected 0", bus.out_valid); end
    checks++; if (bus.acc_out !== '0) begin errors++; $display("FAIL flight_acc_clear: acc_out=%0d expected 0", bus.acc_out); end
    exp_q.delete(); obs_q.delete(); model_acc = 0;
    repeat (3) @(negedge clk);
    arst_n_in = 1'b1;
    bus.out_ready = 1'b1;
    send({16'd0, 16'd0, 16'd7}, {16'd0, 16'd0, 16'd1}, 2'd2, 1'b1, 30);
    drain("flight");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_accum();
    test_psum();
    test_saturate();
    test_back_to_back();
    test_reset_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
